uart_frame_assembler: RTL and testbench

Converts the byte stream from the UART byte receiver into complete 8×8×8 cube frames for the frame buffer. It locates a two-byte sync header and collects 64 payload bytes into a shadow buffer. It then checks a one-byte additive checksum. Only frames that pass the check are committed to the output register, with a one-cycle `frame_valid` pulse; this pulse is the serial-path frame strobe into `frame_buffer`.

---
 rtl/lightcube_pkg.sv | 15 +
 rtl/uart_frame_assembler_gap_timer.sv | 22 ++
 rtl/uart_frame_assembler.sv | 86 ++++++++
 tb/tb_uart_frame_assembler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lightcube_pkg.sv
// Shared lightcube definitions: sync header bytes, frame geometry and the
// assembler state encoding.
package lightcube_pkg;
  localparam logic [7:0] SYNC0       = 8'hA5;
  localparam logic [7:0] SYNC1       = 8'h5A;
  localparam int         FRAME_BYTES = 64;
  localparam int         FRAME_BITS  = FRAME_BYTES * 8;

  typedef enum logic [1:0] {
    HDR0    = 2'd0,
    HDR1    = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } asm_state_t;
endpackage

// File: rtl/uart_frame_assembler_gap_timer.sv
// Inter-byte gap counter; saturates at TIMEOUT_CYCLES and flags expiry while enabled.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) cnt <= '0;
    else if (cnt != LIMIT)       cnt <= cnt + W'(1);
  end

  assign expired = enable && (cnt == LIMIT);
endmodule

// File: rtl/uart_frame_assembler.sv
// Serial byte stream to 8x8x8 cube frame: sync hunt, 64-byte shadow fill,
// additive checksum gate, and commit to the output frame register.
module uart_frame_assembler
  import lightcube_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [FRAME_BITS-1:0] frame_cube_flat,
  output logic                  frame_valid,
  output logic                  csum_err,
  output logic                  timeout_err,
  output logic [7:0]            frame_count
);
  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

  asm_state_t                  state;
  logic [5:0]                  idx;
  logic [7:0]                  sum;
  logic [FRAME_BYTES-1:0][7:0] shadow;
  logic                        gap_expired;

  // A byte in the expiry cycle clears the timer, so the byte always wins.
  gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .enable  (state != HDR0),
    .expired (gap_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= HDR0;
      idx             <= '0;
      sum             <= '0;
      shadow          <= '0;
      frame_cube_flat <= '0;
      frame_valid     <= 1'b0;
      csum_err        <= 1'b0;
      timeout_err     <= 1'b0;
      frame_count     <= '0;
    end else begin
      frame_valid <= 1'b0;
      csum_err    <= 1'b0;
      timeout_err <= 1'b0;
      if (rx_valid) begin
        case (state)
          HDR0: if (rx_data == SYNC0) state <= HDR1;
          HDR1: begin
            if (rx_data == SYNC1) begin
              state <= PAYLOAD;
              idx   <= '0;
              sum   <= '0;
            end else if (rx_data != SYNC0) begin
              state <= HDR0;
            end
          end
          PAYLOAD: begin
            shadow[idx] <= rx_data;
            sum         <= sum + rx_data;
            idx         <= idx + 6'd1;
            if (idx == LAST_IDX) state <= CHECK;
          end
          CHECK: begin
            if (rx_data == sum) begin
              frame_cube_flat <= shadow;
              frame_valid     <= 1'b1;
              frame_count     <= frame_count + 8'd1;
            end else begin
              csum_err <= 1'b1;
            end
            state <= HDR0;
          end
          default: state <= HDR0;
        endcase
      end else if (gap_expired) begin
        state       <= HDR0;
        timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench: each packet or abandoned packet pushes its expected
// pulse; the negedge monitor pops and checks kind, latency, count and frame.
module tb_uart_frame_assembler;
  import lightcube_pkg::*;

  localparam int TO = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [FRAME_BITS-1:0] frame_cube_flat;
  logic                  frame_valid, csum_err, timeout_err;
  logic [7:0]            frame_count;

  uart_frame_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .frame_cube_flat (frame_cube_flat),
    .frame_valid     (frame_valid),
    .csum_err        (csum_err),
    .timeout_err     (timeout_err),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]            kind;   // {frame_valid, csum_err, timeout_err}
    int                    cyc;
    logic [7:0]            cnt;
    logic [FRAME_BITS-1:0] frame;
  } exp_t;

  exp_t                  sb[$];
  exp_t                  it;
  int                    cyc = 0;
  int                    last_cyc = 0;
  int                    n_chk = 0;
  int                    n_fail = 0;
  logic [FRAME_BITS-1:0] model_frame = '0;
  logic [7:0]            model_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [FRAME_BITS-1:0] got,
                       input logic [FRAME_BITS-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller sits #1 after a posedge; the byte is sampled at the next posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc + 1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [2:0] kind, input int c);
    exp_t e;
    e.kind = kind; e.cyc = c; e.cnt = model_count; e.frame = model_frame;
    sb.push_back(e);
  endtask

  task automatic send_pkt(input logic [FRAME_BITS-1:0] pl, input logic [7:0] cs_off);
    logic [7:0] s = 8'd0;
    send_byte(SYNC0);
    send_byte(SYNC1);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      s = s + pl[8*i +: 8];
      send_byte(pl[8*i +: 8]);
    end
    if (cs_off == 8'd0) begin
      model_frame = pl;
      model_count = model_count + 8'd1;
      push(3'b100, cyc + 1);
    end else begin
      push(3'b010, cyc + 1);
    end
    send_byte(s + cs_off);
  endtask

  task automatic send_partial(input int n);
    send_byte(SYNC0);
    send_byte(SYNC1);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  function automatic logic [FRAME_BITS-1:0] rand_payload();
    logic [FRAME_BITS-1:0] p;
    for (int i = 0; i < FRAME_BYTES; i++) p[8*i +: 8] = 8'($urandom);
    return p;
  endfunction

  always @(negedge clk) begin
    if (!rst && (frame_valid || csum_err || timeout_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {frame_valid, csum_err, timeout_err}, 3'b000);
      end else begin
        it = sb.pop_front();
        check("pulse_kind", {frame_valid, csum_err, timeout_err}, it.kind);
        check("pulse_cycle", cyc, it.cyc);
        check("frame_count", frame_count, it.cnt);
        check("frame_data", frame_cube_flat, it.frame);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_BITS-1:0] inc_pl, ff_pl, pl;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      inc_pl[8*i +: 8] = 8'(i);
      ff_pl[8*i +: 8]  = 8'hFF;
    end
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    check("rst_frame", frame_cube_flat, '0);
    check("rst_pulses", {frame_valid, csum_err, timeout_err}, 3'b000);
    check("rst_count", frame_count, 8'd0);

    // good frame (CS 0xE0), then a back-to-back bad checksum
    send_pkt(inc_pl, 8'd0);
    check("good_b63", frame_cube_flat[511:504], 8'h3F);
    check("good_count", frame_count, 8'd1);
    send_pkt(inc_pl, 8'd1);
    idle(2);
    check("bad_keeps_frame", frame_cube_flat, inc_pl);

    // header resync: 00 A5 then A5 5A ..., all-0xFF payload (CS 0xC0)
    send_byte(8'h00);
    send_byte(SYNC0);
    send_pkt(ff_pl, 8'd0);
    check("resync_count", frame_count, 8'd2);

    // timeout after 10 payload bytes, then a good frame
    send_partial(10);
    push(3'b001, last_cyc + TO + 1);
    idle(TO + 4);
    send_pkt(rand_payload(), 8'd0);

    // gap of exactly TO idle cycles is tolerated inside a packet
    pl = rand_payload();
    send_byte(SYNC0);
    send_byte(SYNC1);
    for (int i = 0; i < 10; i++) send_byte(pl[8*i +: 8]);
    idle(TO);
    for (int i = 10; i < FRAME_BYTES; i++) send_byte(pl[8*i +: 8]);
    idle(TO);
    begin
      logic [7:0] s = 8'd0;
      for (int i = 0; i < FRAME_BYTES; i++) s = s + pl[8*i +: 8];
      model_frame = pl;
      model_count = model_count + 8'd1;
      push(3'b100, cyc + 1);
      send_byte(s);
    end

    // one cycle longer than allowed, stalled right after the header
    send_partial(0);
    push(3'b001, last_cyc + TO + 1);
    idle(TO + 1);
    send_pkt(rand_payload(), 8'd0);

    // reset mid-payload
    send_partial(30);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_frame = '0;
    model_count = 8'd0;
    check("midrst_frame", frame_cube_flat, '0);
    check("midrst_pulses", {frame_valid, csum_err, timeout_err}, 3'b000);
    check("midrst_count", frame_count, 8'd0);
    send_pkt(rand_payload(), 8'd0);
    check("post_rst_count", frame_count, 8'd1);

    // wrap: 255 more good frames brings the count back to 0
    for (int f = 0; f < 255; f++) send_pkt(rand_payload(), 8'd0);
    idle(3);
    check("wrap_count", frame_count, 8'd0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
